// File: rtl/collision_pkg.sv
// Shared types, default parameters and helpers for the collision tracker.
package collision_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int DEF_NUM_P_ROCKETS = 1;
  localparam int DEF_NUM_A_ROCKETS = 3;
  localparam int DEF_BORDER_Y      = 479;
  localparam int DEF_HIT_W         = 8;

  // Number of set bits; wide enough for every event vector the tracker builds.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/collision_tracker_event_latch.sv
// One event bit: a once-per-frame "seen" flag plus the registered output pulse.
module event_latch (
  input  logic clk,
  input  logic reset,
  input  logic raw,        // coincidence seen this cycle
  input  logic arm_clear,  // this cycle starts a new frame
  input  logic active,     // tracker is (or is becoming) ACTIVE this cycle
  output logic fire,       // pulse will appear next cycle
  output logic pulse
);

  logic seen_q, seen_d;
  logic pulse_q, pulse_d;
  logic seen_eff;

  // Fire on the first coincidence of a frame; a new frame forgets the old flag.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    seen_eff = arm_clear ? 1'b0 : seen_q;
    fire     = active && raw && !seen_eff;
    seen_d   = active && (seen_eff || fire);
    pulse_d  = fire;
  end

  // Flag and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: only plain flops here, so all of them reset; state uses <= so every flop samples pre-edge values.
    if (reset) begin
      seen_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      seen_q  <= seen_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/collision_tracker.sv
// Per-frame collision event detector: one pulse per event bit per frame and a
// saturating per-frame hit count.
module collision_tracker
  import collision_pkg::*;
#(
  parameter int NUM_P_ROCKETS = DEF_NUM_P_ROCKETS,
  parameter int NUM_A_ROCKETS = DEF_NUM_A_ROCKETS,
  parameter int BORDER_Y      = DEF_BORDER_Y,
  parameter int HIT_W         = DEF_HIT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     startOfFrame,
  input  logic                     drawing_request_player,
  input  logic                     drawing_request_aliens,
  input  logic [NUM_P_ROCKETS-1:0] p_rockets_DR,
  input  logic [NUM_A_ROCKETS-1:0] a_rockets_DR,
  input  logic signed [10:0]       pixelY,
  output logic [NUM_P_ROCKETS-1:0] alienHit,
  output logic [NUM_A_ROCKETS-1:0] playerHitByRocket,
  output logic                     playerHitByAlienPulse,
  output logic [NUM_P_ROCKETS-1:0] p_rocketsCollision,
  output logic [NUM_A_ROCKETS-1:0] a_rocketsCollision,
  output logic                     aliensReachedBorder,
  output logic [HIT_W-1:0]         frame_hits,
  output logic                     armed
);

  localparam int NP = NUM_P_ROCKETS;
  localparam int NA = NUM_A_ROCKETS;

  // Flat event vector layout; hit events occupy the low NH bits.
  localparam int AH_LO = 0;
  localparam int PR_LO = NP;
  localparam int HBA   = NP + NA;
  localparam int PC_LO = NP + NA + 1;
  localparam int AC_LO = 2 * NP + NA + 1;
  localparam int BRD   = 2 * NP + 2 * NA + 1;
  localparam int NE    = 2 * NP + 2 * NA + 2;
  localparam int NH    = NP + NA + 1;

  localparam logic [NE-1:0] HIT_MASK = NE'((64'd1 << NH) - 64'd1);
  localparam logic [31:0]   HIT_MAX  = 32'((64'd1 << HIT_W) - 64'd1);

  state_e state_q, state_d;
  logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [HIT_W-1:0] frame_hits_q, frame_hits_d;

  logic              active;
  logic              new_frame;
  logic [NE-1:0]     raw;
  logic [NE-1:0]     fire;
  logic [NE-1:0]     pulse;
  logic [63:0]       hit_vec;
  logic [31:0]       hit_sum;
  logic signed [31:0] pixel_y_ext;

  // FSM next state; detection runs whenever the next state is ACTIVE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (startOfFrame && enable) state_d = ACTIVE;
      ACTIVE:  if (!enable)                state_d = IDLE;
      default: state_d = IDLE;
    endcase
    active    = (state_d == ACTIVE);
    new_frame = active && startOfFrame;
  end

  // Raw per-cycle coincidence conditions.
  always_comb begin
    raw         = '0;
    pixel_y_ext = 32'(pixelY);
    for (int i = 0; i < NP; i++) begin
      raw[AH_LO + i] = drawing_request_aliens && p_rockets_DR[i];
      raw[PC_LO + i] = p_rockets_DR[i] && (|a_rockets_DR);
    end
    for (int j = 0; j < NA; j++) begin
      raw[PR_LO + j] = drawing_request_player && a_rockets_DR[j];
      raw[AC_LO + j] = a_rockets_DR[j] && (|p_rockets_DR);
    end
    raw[HBA] = drawing_request_aliens && drawing_request_player;
    raw[BRD] = drawing_request_aliens && (pixel_y_ext > BORDER_Y);
  end

  for (genvar g = 0; g < NE; g++) begin : g_evt
    event_latch u_latch (
      .clk       (clk),
      .reset     (reset),
      .raw       (raw[g]),
      .arm_clear (new_frame),
      .active    (active),
      .fire      (fire[g]),
      .pulse     (pulse[g])
    );
  end

  // Hit counter and frame total; rocket-rocket and border events are masked out.
  always_comb begin
    hit_vec          = '0;
    hit_vec[NE-1:0]  = fire & HIT_MASK;
    hit_sum          = (new_frame ? 32'd0 : 32'(hit_cnt_q)) + popcount(hit_vec);
    hit_cnt_d        = '0;
    if (active) begin
      hit_cnt_d = (hit_sum > HIT_MAX) ? HIT_W'(HIT_MAX) : HIT_W'(hit_sum);
    end
    frame_hits_d = new_frame ? hit_cnt_q : frame_hits_q;
  end

  // State, counter and frame-total registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hit_cnt_q    <= '0;
      frame_hits_q <= '0;
    end else begin
      state_q      <= state_d;
      hit_cnt_q    <= hit_cnt_d;
      frame_hits_q <= frame_hits_d;
    end
  end

  assign alienHit              = pulse[AH_LO +: NP];
  assign playerHitByRocket     = pulse[PR_LO +: NA];
  assign playerHitByAlienPulse = pulse[HBA];
  assign p_rocketsCollision    = pulse[PC_LO +: NP];
  assign a_rocketsCollision    = pulse[AC_LO +: NA];
  assign aliensReachedBorder   = pulse[BRD];
  assign frame_hits            = frame_hits_q;
  assign armed                 = (state_q == ACTIVE);

endmodule

// File: tb/tb_collision_tracker.sv
// Scoreboard bench for collision_tracker (default widths plus a HIT_W=2 copy).
module tb_collision_tracker;

  logic clk = 1'b0;
  logic reset;
  logic enable, sof, pl, al;
  logic [0:0] p;
  logic [2:0] a;
  logic signed [10:0] y;

  logic [0:0] alien_hit, pc;
  logic [2:0] prh, ac;
  logic hba, brd, armed;
  logic [7:0] fh;

  logic [0:0] s_alien_hit, s_pc;
  logic [2:0] s_prh, s_ac;
  logic s_hba, s_brd, s_armed;
  logic [1:0] s_fh;

  always #5 clk = ~clk;

  collision_tracker dut (
    .clk(clk), .reset(reset), .enable(enable), .startOfFrame(sof),
    .drawing_request_player(pl), .drawing_request_aliens(al),
    .p_rockets_DR(p), .a_rockets_DR(a), .pixelY(y),
    .alienHit(alien_hit), .playerHitByRocket(prh), .playerHitByAlienPulse(hba),
    .p_rocketsCollision(pc), .a_rocketsCollision(ac), .aliensReachedBorder(brd),
    .frame_hits(fh), .armed(armed)
  );

  collision_tracker #(.HIT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .startOfFrame(sof),
    .drawing_request_player(pl), .drawing_request_aliens(al),
    .p_rockets_DR(p), .a_rockets_DR(a), .pixelY(y),
    .alienHit(s_alien_hit), .playerHitByRocket(s_prh), .playerHitByAlienPulse(s_hba),
    .p_rocketsCollision(s_pc), .a_rocketsCollision(s_ac), .aliensReachedBorder(s_brd),
    .frame_hits(s_fh), .armed(s_armed)
  );

  typedef struct packed {
    logic       ah;
    logic [2:0] prh;
    logic       hba;
    logic       pc;
    logic [2:0] ac;
    logic       brd;
    logic [7:0] fh;
    logic [1:0] fh2;
    logic       armed;
  } obs_t;

  obs_t sb[$];
  int total = 0;
  int bad = 0;
  string cur_test = "";

  // Reference model state.
  logic       m_st;
  logic [9:0] m_seen;
  int         m_hc, m_hc2, m_fh, m_fh2;

  function automatic obs_t get_obs();
    obs_t o;
    o.ah = alien_hit[0]; o.prh = prh; o.hba = hba; o.pc = pc[0]; o.ac = ac;
    o.brd = brd; o.fh = fh; o.fh2 = s_fh; o.armed = armed;
    return o;
  endfunction

  task automatic model_reset();
    m_st = 1'b0; m_seen = '0; m_hc = 0; m_hc2 = 0; m_fh = 0; m_fh2 = 0;
  endtask

  // Drive one cycle of inputs, predict the outputs after the edge, then check.
  task automatic step(input logic i_sof, input logic i_en, input logic i_pl, input logic i_al,
                      input logic i_p, input logic [2:0] i_a, input int i_y);
    logic [9:0] rw, seen_eff, fr;
    logic ev, nf;
    int hits;
    obs_t e, o;
    sof = i_sof; enable = i_en; pl = i_pl; al = i_al; p[0] = i_p; a = i_a; y = 11'(i_y);
    rw[0]   = i_al & i_p;
    rw[3:1] = {3{i_pl}} & i_a;
    rw[4]   = i_al & i_pl;
    rw[5]   = i_p & (|i_a);
    rw[8:6] = {3{i_p}} & i_a;
    rw[9]   = i_al && (i_y > 479);
    ev = i_en && (m_st || i_sof);
    nf = ev && i_sof;
    seen_eff = nf ? 10'd0 : m_seen;
    fr = ev ? (rw & ~seen_eff) : 10'd0;
    m_seen = ev ? (seen_eff | fr) : 10'd0;
    hits = $countones(fr[4:0]);
    if (ev) begin
      if (nf) begin
        m_fh = m_hc; m_fh2 = m_hc2; m_hc = 0; m_hc2 = 0;
      end
      m_hc = (m_hc + hits > 255) ? 255 : m_hc + hits;
      m_hc2 = (m_hc2 + hits > 3) ? 3 : m_hc2 + hits;
    end else begin
      m_hc = 0; m_hc2 = 0;
    end
    m_st = ev;
    e.ah = fr[0]; e.prh = fr[3:1]; e.hba = fr[4]; e.pc = fr[5]; e.ac = fr[8:6];
    e.brd = fr[9]; e.fh = 8'(m_fh); e.fh2 = 2'(m_fh2); e.armed = m_st;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    o = get_obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", cur_test, $time, o, e);
    end
  endtask

  task automatic idle_inputs();
    sof = 0; enable = 0; pl = 0; al = 0; p = '0; a = '0; y = '0;
  endtask

  // Assert reset away from the clock edge and check outputs clear immediately.
  task automatic async_reset();
    obs_t o;
    reset = 1'b1;
    #1;
    o = get_obs();
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL %s async_reset got=%h exp=0", cur_test, o);
    end
    model_reset();
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    idle_inputs();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (get_obs() !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", get_obs());
    end
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 3'b000, 0);
  endtask

  task automatic test_no_arm();
    cur_test = "no_arm";
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 1, 3'b000, 0);
    total++;
    if (alien_hit !== 1'b0 || armed !== 1'b0) begin
      bad++;
      $display("FAIL no_arm alienHit=%b armed=%b exp 0 0", alien_hit, armed);
    end
  endtask

  task automatic test_rocket_hit();
    cur_test = "rocket_hit";
    step(1, 1, 0, 0, 0, 3'b000, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 3'b101, 0);
    step(1, 1, 0, 0, 0, 3'b000, 0);
    total++;
    if (fh !== 8'd2) begin
      bad++;
      $display("FAIL rocket_hit_frame_hits got=%0d exp=2", fh);
    end
  endtask

  task automatic test_sof_overlap();
    cur_test = "sof_overlap";
    step(1, 1, 1, 0, 0, 3'b101, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 3'b101, 0);
    step(1, 1, 1, 0, 0, 3'b101, 0);
    total++;
    if (prh !== 3'b101 || fh !== 8'd2) begin
      bad++;
      $display("FAIL sof_overlap prh=%b fh=%0d exp 101 2", prh, fh);
    end
    step(0, 1, 0, 0, 0, 3'b000, 0);
  endtask

  task automatic test_rocket_collision();
    int fh_before;
    cur_test = "rocket_collision";
    step(1, 1, 0, 0, 0, 3'b000, 0);
    fh_before = m_fh;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 3'b010, 0);
    step(1, 1, 0, 0, 0, 3'b000, 0);
    total++;
    if (fh !== 8'd0 || int'(fh) == fh_before + 1) begin
      bad++;
      $display("FAIL rocket_collision_no_count fh=%0d exp=0", fh);
    end
  endtask

  task automatic test_saturation();
    cur_test = "saturation";
    step(1, 1, 0, 0, 0, 3'b000, 0);
    step(0, 1, 1, 1, 1, 3'b111, 0);
    step(0, 1, 1, 1, 1, 3'b111, 0);
    step(1, 1, 0, 0, 0, 3'b000, 0);
    total++;
    if (s_fh !== 2'd3 || fh !== 8'd5) begin
      bad++;
      $display("FAIL saturation fh2=%0d fh=%0d exp 3 5", s_fh, fh);
    end
  endtask

  task automatic test_border_and_reset();
    cur_test = "border";
    step(1, 1, 0, 0, 0, 3'b000, 0);
    step(0, 1, 0, 1, 0, 3'b000, 479);
    step(0, 1, 0, 1, 0, 3'b000, 479);
    step(0, 1, 0, 1, 0, 3'b000, 480);
    step(0, 1, 0, 1, 0, 3'b000, 480);
    step(0, 1, 0, 1, 0, 3'b000, -5);
    cur_test = "mid_reset";
    step(0, 1, 1, 1, 1, 3'b000, 0);
    async_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 3'b011, 600);
    step(1, 1, 1, 1, 1, 3'b011, 600);
    total++;
    if (alien_hit !== 1'b1 || brd !== 1'b1 || armed !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_arm ah=%b brd=%b armed=%b exp 1 1 1", alien_hit, brd, armed);
    end
  endtask

  task automatic test_disable();
    cur_test = "disable";
    step(0, 1, 0, 0, 0, 3'b000, 0);
    step(0, 0, 1, 1, 1, 3'b111, 0);
    step(0, 1, 1, 1, 1, 3'b111, 0);
    step(1, 1, 0, 0, 0, 3'b000, 0);
    step(1, 1, 0, 0, 0, 3'b000, 0);
  endtask

  initial begin
    test_reset();
    test_no_arm();
    test_rocket_hit();
    test_sof_overlap();
    test_rocket_collision();
    test_saturation();
    test_border_and_reset();
    test_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
